// File: rtl/telemetry_pkg.sv
// Shared constants and state encoding for the position telemetry transmitter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package telemetry_pkg;

  localparam logic [7:0] TLM_HDR       = 8'hA5;
  localparam int         TLM_FRAME_LEN = 9;
  localparam int         TLM_IDX_W     = 4;

  // Index of the checksum byte, the final byte of every frame.
  localparam logic [TLM_IDX_W-1:0] TLM_LAST_IDX = TLM_IDX_W'(TLM_FRAME_LEN - 1);

  typedef enum logic {
    TLM_IDLE = 1'b0,
    TLM_SEND = 1'b1
  } tlm_state_t;

endpackage

// File: rtl/telem_byte_sel.sv
// Frame byte mux: picks header, sequence, X/Y/Z big-endian bytes or checksum by index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected byte is registered.
// Ports: idx (byte index), seq, snap_x/y/z (16-bit zero-extended snapshot),
//        csum (running checksum), byte_dat (selected byte).
module telem_byte_sel
  import telemetry_pkg::*;
(
  input  logic [TLM_IDX_W-1:0] idx,
  input  logic [7:0]           seq,
  input  logic [15:0]          snap_x,
  input  logic [15:0]          snap_y,
  input  logic [15:0]          snap_z,
  input  logic [7:0]           csum,
  output logic [7:0]           byte_dat
);

  always_comb begin
    byte_dat = 8'h00;
    case (idx)
      4'd0:    byte_dat = TLM_HDR;
      4'd1:    byte_dat = seq;
      4'd2:    byte_dat = snap_x[15:8];
      4'd3:    byte_dat = snap_x[7:0];
      4'd4:    byte_dat = snap_y[15:8];
      4'd5:    byte_dat = snap_y[7:0];
      4'd6:    byte_dat = snap_z[15:8];
      4'd7:    byte_dat = snap_z[7:0];
      4'd8:    byte_dat = csum;
      default: byte_dat = 8'h00;
    endcase
  end

endmodule

// File: rtl/position_telemetry_tx.sv
// Snapshots X/Y/Z positions on start and sends a 9-byte framed stream with sequence and checksum.
// Latency: start at edge N gives header byte valid after edge N; one byte per cycle when ready.
// Backpressure: tx_ready low holds tx_data/tx_last; start while busy is dropped and flagged by overrun.
// Ports: clk, rst_n (async active-low), pos_x/y/z [W], start, tx_ready in;
//        tx_data [8], tx_valid, tx_last, busy, overrun out (all registered).
module position_telemetry_tx
  import telemetry_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pos_x,
  input  logic [W-1:0] pos_y,
  input  logic [W-1:0] pos_z,
  input  logic         start,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         tx_last,
  output logic         busy,
  output logic         overrun
);

  tlm_state_t           state, state_d;
  logic [TLM_IDX_W-1:0] idx, idx_d;
  logic [7:0]           seq, seq_d;
  logic [7:0]           csum, csum_d;
  logic [15:0]          snap_x, snap_y, snap_z;
  logic [15:0]          snap_x_d, snap_y_d, snap_z_d;
  logic [15:0]          ext_x, ext_y, ext_z;
  logic [7:0]           sel_dat;
  logic                 hs;

  // Zero-extend without a replication that would be zero-width at W=16.
  always_comb begin
    ext_x = '0;
    ext_y = '0;
    ext_z = '0;
    ext_x[W-1:0] = pos_x;
    ext_y[W-1:0] = pos_y;
    ext_z[W-1:0] = pos_z;
  end

  assign hs = tx_valid & tx_ready;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    seq_d    = seq;
    csum_d   = csum;
    snap_x_d = snap_x;
    snap_y_d = snap_y;
    snap_z_d = snap_z;
    case (state)
      TLM_IDLE: begin
        if (start) begin
          state_d  = TLM_SEND;
          idx_d    = '0;
          csum_d   = 8'h00;
          snap_x_d = ext_x;
          snap_y_d = ext_y;
          snap_z_d = ext_z;
        end
      end
      TLM_SEND: begin
        if (hs) begin
          if (idx == TLM_LAST_IDX) begin
            state_d = TLM_IDLE;
            idx_d   = '0;
            seq_d   = seq + 8'd1;
          end else begin
            idx_d = idx + TLM_IDX_W'(1);
            // Header is excluded from the checksum; bytes 1..7 are summed.
            if (idx != '0) begin
              csum_d = csum + tx_data;
            end
          end
        end
      end
      default: state_d = TLM_IDLE;
    endcase
  end

  // The output byte is selected from next-state values so tx_data is a plain
  // register with no path from tx_ready or start.
  telem_byte_sel u_byte_sel (
    .idx      (idx_d),
    .seq      (seq_d),
    .snap_x   (snap_x_d),
    .snap_y   (snap_y_d),
    .snap_z   (snap_z_d),
    .csum     (csum_d),
    .byte_dat (sel_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TLM_IDLE;
      idx      <= '0;
      seq      <= 8'h00;
      csum     <= 8'h00;
      snap_x   <= 16'h0000;
      snap_y   <= 16'h0000;
      snap_z   <= 16'h0000;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      seq      <= seq_d;
      csum     <= csum_d;
      snap_x   <= snap_x_d;
      snap_y   <= snap_y_d;
      snap_z   <= snap_z_d;
      tx_valid <= (state_d == TLM_SEND);
      busy     <= (state_d == TLM_SEND);
      tx_last  <= (state_d == TLM_SEND) && (idx_d == TLM_LAST_IDX);
      tx_data  <= (state_d == TLM_SEND) ? sel_dat : 8'h00;
      // Covers the final-handshake cycle too, since state is still SEND then.
      overrun  <= start & (state == TLM_SEND);
    end
  end

endmodule
